adder_operand_feeder: RTL and testbench

//  Initiator side of the parallel_adder operand interface. Accepts 4-bit operands serially over a

---
 rtl/adder_pkg.sv | 8 +
 rtl/adder_operand_feeder_if.sv | 23 ++
 rtl/feeder_latency_timer.sv | 18 +
 rtl/adder_operand_feeder.sv | 66 ++++++
 tb/tb_adder_operand_feeder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared adder-tree parameters and feeder state encoding.
package adder_pkg;
  localparam int NUM_OPS  = 8;
  localparam int OP_W     = 4;
  localparam int SUM_W    = 15;
  localparam int PIPE_LAT = 3;
  typedef enum logic [1:0] {FILL, WAIT, DONE} feeder_state_e;
endpackage

// File: rtl/adder_operand_feeder_if.sv
// adder_operand_feeder_if: operand stream, adder-side frame/sum and result stream.
interface adder_operand_feeder_if;
  import adder_pkg::*;
  logic                    in_valid;
  logic                    in_ready;
  logic [OP_W-1:0]         in_data;
  logic                    flush;
  logic [NUM_OPS*OP_W-1:0] ops_flat;
  logic                    ops_valid;
  logic [SUM_W-1:0]        sum_in;
  logic                    res_valid;
  logic                    res_ready;
  logic [SUM_W-1:0]        res_sum;
  logic                    busy;
  modport master (
    input  in_valid, in_data, flush, sum_in, res_ready,
    output in_ready, ops_flat, ops_valid, res_valid, res_sum, busy
  );
  modport slave (
    output in_valid, in_data, flush, sum_in, res_ready,
    input  in_ready, ops_flat, ops_valid, res_valid, res_sum, busy
  );
endinterface

// File: rtl/feeder_latency_timer.sv
// feeder_latency_timer: loadable down-counter that parks at zero and flags it.
module feeder_latency_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/adder_operand_feeder.sv
// adder_operand_feeder: collects a serial operand frame, drives the adder tree, returns its sum.
module adder_operand_feeder
  import adder_pkg::*;
(
  input logic clk,
  input logic rst_n,
  adder_operand_feeder_if.master bus
);
  localparam int CW = $clog2(NUM_OPS);
  localparam int LW = $clog2(PIPE_LAT + 1);
  feeder_state_e state, state_nx;
  logic [CW-1:0] op_cnt;
  logic [NUM_OPS*OP_W-1:0] shadow, shadow_wr;
  logic accept, last, frame_done, lat_zero;
  assign accept     = bus.in_valid && state == FILL;
  assign last       = op_cnt == CW'(NUM_OPS - 1);
  assign frame_done = accept && last && !bus.flush;
  always_comb begin
    shadow_wr = shadow;
    shadow_wr[op_cnt*OP_W +: OP_W] = bus.in_data;
  end
  always_comb begin
    bus.in_ready = state == FILL;
    bus.busy     = !(state == FILL && op_cnt == '0);
    state_nx     = frame_done ? WAIT :
                   (state == WAIT && lat_zero) ? DONE :
                   (state == DONE && bus.res_ready) ? FILL : state;
  end
  feeder_latency_timer #(.W(LW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_done),
    .en       (state == WAIT),
    .load_val (LW'(PIPE_LAT)),
    .zero     (lat_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= FILL;
      op_cnt        <= '0;
      shadow        <= '0;
      bus.ops_flat  <= '0;
      bus.ops_valid <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
    end else begin
      state         <= state_nx;
      bus.ops_valid <= frame_done;
      if (state == FILL && bus.flush) begin
        op_cnt <= '0;
        shadow <= '0;
      end else if (accept) begin
        shadow <= shadow_wr;
        if (!last) op_cnt <= op_cnt + 1'b1;
      end else if (state == DONE && bus.res_ready) begin
        op_cnt <= '0;
      end
      if (frame_done) bus.ops_flat <= shadow_wr;
      if (state == WAIT && lat_zero) begin
        bus.res_sum   <= bus.sum_in;
        bus.res_valid <= 1'b1;
      end else if (state == DONE && bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_adder_operand_feeder.sv
// tb_adder_operand_feeder: scoreboard bench with a popcount adder-tree model behind the feeder.
module tb_adder_operand_feeder;
  import adder_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  adder_operand_feeder_if bus ();
  adder_operand_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [SUM_W-1:0] p0, p1, p2;
  always @(posedge clk) begin
    p0 <= SUM_W'($countones(bus.ops_flat));
    p1 <= p0;
    p2 <= p1;
  end
  assign bus.sum_in = p2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ops_q[$];
  logic [31:0] sum_q[$];
  logic res_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) res_prev = 1'b0;
    else begin
      if (bus.ops_valid) begin
        if (ops_q.size() == 0) chk("unexpected_ops_valid", 32'd1, 32'd0);
        else chk("ops_flat", bus.ops_flat, ops_q.pop_front());
      end
      if (bus.res_valid && !res_prev) begin
        if (sum_q.size() == 0) chk("unexpected_res_valid", 32'd1, 32'd0);
        else chk("res_sum", 32'(bus.res_sum), sum_q.pop_front());
      end
      res_prev = bus.res_valid;
    end
  end

  task automatic send_beat(input logic [3:0] d, input int gap);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 4'(($urandom));
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] ops, input logic [31:0] sum, input int gap);
    ops_q.push_back(ops);
    sum_q.push_back(sum);
    for (int k = 0; k < NUM_OPS; k++) begin
      logic [31:0] v;
      v = ops >> (k * OP_W);
      send_beat(v[3:0], k == NUM_OPS - 1 ? 0 : gap);
    end
    chk("ops_valid_pulse", 32'(bus.ops_valid), 32'd1);
    chk("in_ready_wait", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_res(input logic [31:0] ops);
    int c = 0;
    while (!bus.res_valid && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("ops_valid_single", 32'(bus.ops_valid), 32'd0);
      chk("ops_hold", bus.ops_flat, ops);
    end
    chk("capture_latency", 32'(c), 32'(PIPE_LAT + 1));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.res_ready = 1'b1;
    #12;
    chk("rst_ops_flat", bus.ops_flat, 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_sum", 32'(bus.res_sum), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ops_valid", 32'(bus.ops_valid), 32'd0);

    send_frame(32'hFFFFFFFF, 32'd32, 0);
    wait_res(32'hFFFFFFFF);
    @(negedge clk);

    ops_q.push_back(32'h87654321);
    sum_q.push_back(32'd13);
    send_beat(4'h1, 2);
    chk("busy_partial", 32'(bus.busy), 32'd1);
    for (int k = 2; k <= 8; k++) send_beat(4'(k), k == 8 ? 0 : 1);
    chk("ops_valid_pulse2", 32'(bus.ops_valid), 32'd1);
    wait_res(32'h87654321);
    @(negedge clk);

    repeat (5) send_beat(4'hF, 0);
    chk("busy_before_flush", 32'(bus.busy), 32'd1);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("busy_after_flush", 32'(bus.busy), 32'd0);
    send_frame(32'h11111111, 32'd8, 0);
    wait_res(32'h11111111);
    @(negedge clk);

    bus.res_ready = 1'b0;
    send_frame(32'hAAAAAAAA, 32'd16, 0);
    wait_res(32'hAAAAAAAA);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("done_res_valid", 32'(bus.res_valid), 32'd1);
      chk("done_res_sum", 32'(bus.res_sum), 32'd16);
      chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("done_release", 32'(bus.res_valid), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);

    send_frame(32'h55555555, 32'd16, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ops_flat", bus.ops_flat, 32'h0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    sum_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(32'h33333333, 32'd16, 0);
    wait_res(32'h33333333);
    @(negedge clk);

    send_frame(32'h77777777, 32'd24, 0);
    bus.flush = 1'b1;
    wait_res(32'h77777777);
    chk("t6_in_ready_done", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("t6_in_ready_fill", 32'(bus.in_ready), 32'd1);
    chk("t6_res_valid", 32'(bus.res_valid), 32'd0);
    chk("t6_ops_kept", bus.ops_flat, 32'h77777777);
    chk("t6_res_sum_kept", 32'(bus.res_sum), 32'd24);

    repeat (4) @(negedge clk);
    chk("ops_q_drained", 32'(ops_q.size()), 32'd0);
    chk("sum_q_drained", 32'(sum_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
